// File: rtl/moving_average_cfg.sv
// moving_average_cfg: moving-average filter with a window of 2^p samples, where p
// is chosen at run time. An optional 2-tap cascade stage can follow it.
// All window lengths share one circular sample buffer. The filter re-primes
// itself on every configuration change.
module moving_average_cfg #(
    parameter int DATA_IN_LEN = 10,
    parameter int MAX_POWER   = 4,
    parameter int SEL_W       = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_IN_LEN-1:0] data_in,
    input  logic                   strobe_in,
    input  logic [SEL_W-1:0]       win_sel,
    input  logic                   cascade_en,
    output logic [DATA_IN_LEN-1:0] data_out,
    output logic                   strobe_out,
    output logic                   settled
);

    localparam int DEPTH = 1 << MAX_POWER;
    localparam int SUM_W = DATA_IN_LEN + MAX_POWER;
    localparam int PTR_W = MAX_POWER;
    localparam int CNT_W = MAX_POWER + 1;

    typedef enum logic {FILL, RUN} state_t;

    // Window average: truncate the running sum by the window power.
    function automatic logic [DATA_IN_LEN-1:0] shift_trunc(input logic [SUM_W-1:0] s,
                                                            input logic [SEL_W-1:0] p);
        return DATA_IN_LEN'(s >> p);
    endfunction

    // Two-tap average. The extra bit in the intermediate holds the carry.
    function automatic logic [DATA_IN_LEN-1:0] avg2(input logic [DATA_IN_LEN-1:0] a,
                                                     input logic [DATA_IN_LEN-1:0] b);
        return DATA_IN_LEN'(({1'b0, a} + {1'b0, b}) >> 1);
    endfunction

    logic [DATA_IN_LEN-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [SUM_W-1:0]       sum_q;
    logic [CNT_W-1:0]       fill_cnt;
    logic [SEL_W-1:0]       p_q;
    logic                   casc_q;
    state_t                 state;

    logic [SEL_W-1:0]       p_sel;
    logic                   cfg_change;
    logic [CNT_W-1:0]       win_p0;
    logic [PTR_W-1:0]       rd_idx_p0;
    logic [DATA_IN_LEN-1:0] old_p0;
    logic [SUM_W-1:0]       sum_base_p0;
    logic [CNT_W-1:0]       fill_base_p0;
    logic [SUM_W-1:0]       sum_p0;
    logic [CNT_W-1:0]       fill_p0;
    logic                   full_p0;
    logic [DATA_IN_LEN-1:0] s1_p0;

    logic [DATA_IN_LEN-1:0] s1_p1;
    logic                   full_p1;
    logic                   vld_p1;
    logic [DATA_IN_LEN-1:0] prev;

    // Stage 0: clamp the configuration and compute the updated window sum.
    // A sample that arrives together with a config change starts from an
    // empty window.
    always_comb begin
        p_sel        = (win_sel > SEL_W'(MAX_POWER)) ? SEL_W'(MAX_POWER) : win_sel;
        cfg_change   = (p_sel != p_q) || (cascade_en != casc_q);
        win_p0       = CNT_W'(1) << p_sel;
        // At the maximum window this index equals wr_ptr. The read sees the
        // value from before this cycle's write.
        rd_idx_p0    = wr_ptr - win_p0[PTR_W-1:0];
        sum_base_p0  = cfg_change ? '0 : sum_q;
        fill_base_p0 = cfg_change ? '0 : fill_cnt;
        old_p0       = (!cfg_change && fill_cnt == win_p0) ? mem[rd_idx_p0] : '0;
        // The sum can wrap in the middle of this expression. The final result
        // is still exact, because old_p0 is always part of sum_base_p0.
        sum_p0       = sum_base_p0 + SUM_W'(data_in) - SUM_W'(old_p0);
        fill_p0      = (fill_base_p0 == win_p0) ? fill_base_p0 : fill_base_p0 + CNT_W'(1);
        full_p0      = (fill_p0 == win_p0);
        s1_p0        = shift_trunc(sum_p0, p_sel);
    end

    // Sample buffer. Its contents never need clearing, because fill_cnt
    // decides which entries count.
    always_ff @(posedge clk) begin
        if (strobe_in) mem[wr_ptr] <= data_in;
    end

    // Control state: configuration tracking, window bookkeeping, the
    // FILL/RUN state machine, and both output stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q      <= '0;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            prev       <= '0;
            s1_p1      <= '0;
            full_p1    <= 1'b0;
            vld_p1     <= 1'b0;
            state      <= FILL;
            p_q        <= p_sel;
            casc_q     <= cascade_en;
            data_out   <= '0;
            strobe_out <= 1'b0;
            settled    <= 1'b0;
        end else begin
            strobe_out <= 1'b0;
            vld_p1     <= strobe_in && cascade_en;

            if (cfg_change) begin
                // Re-prime. Any cascade result still in flight is dropped.
                p_q      <= p_sel;
                casc_q   <= cascade_en;
                state    <= FILL;
                sum_q    <= '0;
                fill_cnt <= '0;
                prev     <= '0;
            end else if (vld_p1) begin
                // Stage 2: cascade output. In RUN, prev already holds the
                // average of a full window.
                data_out   <= avg2(s1_p1, prev);
                strobe_out <= 1'b1;
                settled    <= full_p1 && (state == RUN);
                prev       <= s1_p1;
                if (full_p1) state <= RUN;
            end

            // Stage 1: accept the sample. Register the window average, either
            // as the output or for the cascade stage.
            if (strobe_in) begin
                sum_q    <= sum_p0;
                fill_cnt <= fill_p0;
                wr_ptr   <= wr_ptr + PTR_W'(1);
                if (cascade_en) begin
                    s1_p1   <= s1_p0;
                    full_p1 <= full_p0;
                end else begin
                    data_out   <= s1_p0;
                    strobe_out <= 1'b1;
                    settled    <= full_p0;
                    state      <= full_p0 ? RUN : FILL;
                end
            end
        end
    end

endmodule

// File: tb/tb_moving_average_cfg.sv
// Testbench for moving_average_cfg. Most checks come from a table of directed
// vectors, where each row gives one cycle's inputs and the outputs expected
// after that clock edge. Looped sequences cover the largest window.
module tb_moving_average_cfg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] data_in = '0;
    logic       strobe_in = 1'b0;
    logic [2:0] win_sel = 3'd0;
    logic       cascade_en = 1'b0;
    logic [9:0] data_out;
    logic       strobe_out;
    logic       settled;

    int checks = 0;
    int failures = 0;

    moving_average_cfg #(.DATA_IN_LEN(10), .MAX_POWER(4), .SEL_W(3)) dut (
        .clk(clk),
        .reset(reset),
        .data_in(data_in),
        .strobe_in(strobe_in),
        .win_sel(win_sel),
        .cascade_en(cascade_en),
        .data_out(data_out),
        .strobe_out(strobe_out),
        .settled(settled)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic stb;
        int   din;
        int   ws;
        logic ce;
        logic e_stb;
        int   e_dat;
        logic e_set;
        string tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic stb, input int din, input int ws,
                       input logic ce, input logic e_stb, input int e_dat,
                       input logic e_set, input string tag);
        vec_t v;
        v.rst = rst; v.stb = stb; v.din = din; v.ws = ws; v.ce = ce;
        v.e_stb = e_stb; v.e_dat = e_dat; v.e_set = e_set; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge. Return just after the next
    // rising edge, where the outputs can be sampled.
    task automatic drive(input logic rst, input logic stb, input int din, input int ws,
                         input logic ce);
        @(negedge clk);
        reset      = rst;
        strobe_in  = stb;
        data_in    = 10'(din);
        win_sel    = 3'(ws);
        cascade_en = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic e_stb, input int e_dat,
                           input logic e_set);
        chk({tag, ".strobe_out"}, int'(strobe_out), int'(e_stb));
        chk({tag, ".data_out"}, int'(data_out), e_dat);
        chk({tag, ".settled"}, int'(settled), int'(e_set));
    endtask

    initial begin
        int exp_d;
        int s;
        int q[$];

        // A: p=2, no cascade, steady 100.
        add(1, 0, 0,   2, 0, 0, 0,   0, "A.reset");
        add(0, 1, 100, 2, 0, 1, 25,  0, "A.s1");
        add(0, 1, 100, 2, 0, 1, 50,  0, "A.s2");
        add(0, 1, 100, 2, 0, 1, 75,  0, "A.s3");
        add(0, 1, 100, 2, 0, 1, 100, 1, "A.s4");
        add(0, 1, 100, 2, 0, 1, 100, 1, "A.s5");
        add(0, 0, 0,   2, 0, 0, 100, 1, "A.idle");
        // C: p=1 with cascade, inputs 0,0,200,200,200. Latency is 2 cycles.
        add(1, 0, 0,   1, 1, 0, 0,   0, "C.reset");
        add(0, 1, 0,   1, 1, 0, 0,   0, "C.s1");
        add(0, 1, 0,   1, 1, 1, 0,   0, "C.s2");
        add(0, 1, 200, 1, 1, 1, 0,   0, "C.s3");
        add(0, 1, 200, 1, 1, 1, 50,  1, "C.s4");
        add(0, 1, 200, 1, 1, 1, 150, 1, "C.s5");
        add(0, 0, 0,   1, 1, 1, 200, 1, "C.d1");
        add(0, 0, 0,   1, 1, 0, 200, 1, "C.d2");
        // D: steady RUN at p=3 on 80, then switch to p=1 with a strobe of 40.
        add(1, 0, 0,   3, 0, 0, 0,   0, "D.reset");
        for (int k = 1; k <= 8; k++)
            add(0, 1, 80, 3, 0, 1, 10 * k, (k == 8), $sformatf("D.s%0d", k));
        add(0, 1, 40,  1, 0, 1, 20,  0, "D.chg");
        add(0, 1, 40,  1, 0, 1, 40,  1, "D.after");
        // F: reset in mid-stream at p=2. The strobe during reset is dropped.
        add(1, 0, 0,   2, 0, 0, 0,   0, "F.reset");
        add(0, 1, 200, 2, 0, 1, 50,  0, "F.s1");
        add(0, 1, 200, 2, 0, 1, 100, 0, "F.s2");
        add(0, 1, 200, 2, 0, 1, 150, 0, "F.s3");
        add(1, 1, 200, 2, 0, 0, 0,   0, "F.midreset");
        add(0, 1, 100, 2, 0, 1, 25,  0, "F.n1");
        add(0, 1, 100, 2, 0, 1, 50,  0, "F.n2");
        add(0, 1, 100, 2, 0, 1, 75,  0, "F.n3");
        // G: config change while a cascade result is in flight. The result is
        // discarded and prev is cleared.
        add(1, 0, 0,   1, 1, 0, 0,   0, "G.reset");
        add(0, 1, 100, 1, 1, 0, 0,   0, "G.s1");
        add(0, 0, 0,   2, 1, 0, 0,   0, "G.chg");
        add(0, 0, 0,   2, 1, 0, 0,   0, "G.idle");
        add(0, 1, 100, 2, 1, 0, 0,   0, "G.s2");
        add(0, 0, 0,   2, 1, 1, 12,  0, "G.out");
        add(0, 0, 0,   2, 1, 0, 12,  0, "G.hold");

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stb, vecs[i].din, vecs[i].ws, vecs[i].ce);
            chk_out(vecs[i].tag, vecs[i].e_stb, vecs[i].e_dat, vecs[i].e_set);
        end

        // B: p=4, back-to-back strobes of 1023. The sum reaches its maximum.
        drive(1, 0, 0, 4, 0);
        chk_out("B.reset", 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            drive(0, 1, 1023, 4, 0);
            exp_d = ((k < 16 ? k : 16) * 1023) >> 4;
            chk_out($sformatf("B.s%0d", k), 1, exp_d, (k >= 16));
        end

        // E: win_sel=7 clamps to p=4. Varying data exercises the wrap-around
        // read of the oldest entry.
        drive(1, 0, 0, 7, 0);
        chk_out("E.reset", 0, 0, 0);
        for (int k = 1; k <= 24; k++) begin
            q.push_back(k * 10);
            if (q.size() > 16) void'(q.pop_front());
            s = 0;
            foreach (q[j]) s += q[j];
            drive(0, 1, k * 10, 7, 0);
            chk_out($sformatf("E.s%0d", k), 1, s >> 4, (k >= 16));
        end

        drive(0, 0, 0, 7, 0);
        chk("E.idle.strobe_out", int'(strobe_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/moving_average_cfg.md
# moving_average_cfg

Runtime-configurable moving-average filter, successor to the fixed-window filter bank. One circular sample buffer of depth 2^MAX_POWER serves every window length 2^p, p = 0..MAX_POWER, selected at run time. An optional 2-tap cascade stage can be enabled at run time. On any configuration change the filter re-primes explicitly, and a `settled` flag marks the first fully-populated output. It sits between the pad-level input mux and the output register in the top-level wrapper.

## Interface
- DATA_IN_LEN, 10, sample width (unsigned)
- MAX_POWER, 4, log2 of maximum window; buffer depth 2^MAX_POWER
- SEL_W, 3, width of win_sel; must satisfy 2^SEL_W > MAX_POWER

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- data_in  in  DATA_IN_LEN  input sample, qualified by strobe_in
- strobe_in  in  1  one-cycle sample-valid pulse; back-to-back cycles allowed
- win_sel  in  SEL_W  window power p; values > MAX_POWER clamp to MAX_POWER
- cascade_en  in  1  1 = append 2-tap average stage
- data_out  out  DATA_IN_LEN  filtered sample
- strobe_out  out  1  one-cycle pulse, data_out valid
- settled  out  1  qualifies data_out; window (and cascade history) completely filled since last reset or config change

## Operation
- Buffer: 2^MAX_POWER x DATA_IN_LEN, write pointer wr_ptr (MAX_POWER bits, wraps modulo depth). Running sum: DATA_IN_LEN+MAX_POWER bits, unsigned, never overflows.
- Fill counter fill_cnt (MAX_POWER+1 bits) saturates at 2^p.
- Accepted sample (strobe_in=1):
  - old = buf[wr_ptr - 2^p] if fill_cnt == 2^p, else 0.
  - sum <= sum + data_in - old; buf[wr_ptr] <= data_in; wr_ptr++.
  - fill_cnt++ (saturating).
- Stage-1 result s1 = sum_new >> p, truncation toward zero.
- Cascade (cascade_en=1): out = (s1 + prev) >> 1, with a DATA_IN_LEN+1-bit intermediate; then prev <= s1. prev is cleared on reset/config change.
- State machine (clamped p and cascade_en registered as cfg_q):
  - FILL: fill_cnt < 2^p, or cascade enabled and prev not yet loaded since the stage-1 window filled. settled=0.
  - RUN: window full (and prev loaded if cascade). settled=1.
  - FILL -> RUN on the accepted sample that completes the condition. RUN -> FILL on any config change.
- Config change: (clamped win_sel, cascade_en) != cfg_q in a cycle.
  - Update cfg_q; sum, fill_cnt, prev reset; state -> FILL; buffer contents kept but treated as empty through fill_cnt.
  - If strobe_in coincides, that sample is the first sample of the new configuration: sum <= data_in, fill_cnt <= 1.
- Output during FILL: zero-prefill semantics (missing samples count as 0); strobe_out still pulses.
- p = 0: pass-through of each sample, settled after the first sample.

## Timing
- Reset values: data_out=0, strobe_out=0, settled=0. Internal: sum=0, wr_ptr=0, fill_cnt=0, prev=0, state=FILL, cfg_q=current inputs. Buffer need not be cleared.
- Latency strobe_in -> strobe_out:
  - 1 cycle with cascade_en=0.
  - 2 cycles with cascade_en=1: the stage-2 register follows stage 1.
- data_out and settled update only in the strobe_out cycle and hold otherwise.
- Throughput: one sample per cycle sustained, no stalls, no backpressure.
- Reset asserted mid-stream: in-flight strobes are dropped; strobe_out=0 on the cycle after the reset cycle.
- Config change while a cascade stage-2 result is in flight: that result is discarded, with no strobe_out.
- Wrap-around: at p = MAX_POWER the oldest entry is the one overwritten in the same cycle. The read must return the pre-write value.

## Test plan
- p=2, cascade off, five strobes of 100 after reset -> data_out 25, 50, 75, 100, 100, each 1 cycle after its strobe; settled goes 1 on the 4th output.
- p=4, twenty back-to-back strobes of 1023 -> outputs 63, 127, ..., 1023; settled from the 16th output; checks no sum overflow and the wrap read-before-write.
- p=1, cascade on, inputs 0, 0, 200, 200, 200 -> data_out 0, 0, 50, 150, 200 at 2-cycle latency; settled from the 3rd output.
- Steady RUN at p=3 on 80, then win_sel->1 in the same cycle as a strobe of 40 -> next output 20 with settled=0; the next strobe of 40 -> 40 with settled=1.
- win_sel=7 with MAX_POWER=4 -> behaves as p=4: settled after the 16th strobe.
- Reset pulsed mid-stream at p=2 -> no strobe_out the following cycle; the next three strobes of 100 give 25, 50, 75, confirming the old history is gone.
